// File: rtl/mulpop_pkg.sv
// Shared types and widths for the multiply/popcount scheduler.
package mulpop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int A_W    = 24;
    localparam int W_W    = 32;
    localparam int ONES_W = 6;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/mulpop_sched_if.sv
// Requester and engine signal bundle for mulpop_sched; slave is the scheduler side.
interface mulpop_sched_if
    import mulpop_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ*A_W-1:0] req_a1;
    logic [N_REQ*A_W-1:0] req_a2;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     rsp_valid;
    logic [W_W-1:0]       rsp_w;
    logic [ONES_W-1:0]    rsp_ones;
    logic                 rsp_ovf;
    logic                 rsp_err;

    logic                 eng_start;
    logic [A_W-1:0]       eng_a1;
    logic [A_W-1:0]       eng_a2;
    logic                 eng_done;
    logic [W_W-1:0]       eng_w;
    logic [ONES_W-1:0]    eng_ones;
    logic                 eng_ovf;

    modport slave (
        input  req, req_a1, req_a2, eng_done, eng_w, eng_ones, eng_ovf,
        output grant, rsp_valid, rsp_w, rsp_ones, rsp_ovf, rsp_err,
               eng_start, eng_a1, eng_a2
    );

    modport master (
        output req, req_a1, req_a2, eng_done, eng_w, eng_ones, eng_ovf,
        input  grant, rsp_valid, rsp_w, rsp_ones, rsp_ovf, rsp_err,
               eng_start, eng_a1, eng_a2
    );
endinterface

// File: rtl/mulpop_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mulpop_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IDX_W'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mulpop_sched.sv
// Round-robin scheduler sharing one multicycle multiply+popcount engine among N_REQ requesters.
// Define MULPOP_TIMEOUT_EN to abort an operation whose engine stays silent for TIMEOUT cycles.
module mulpop_sched
    import mulpop_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                n_reset,
    mulpop_sched_if.slave       bus,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               done_hit;
    logic               to_hit;

    mulpop_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign done_hit = (state == WAIT) && bus.eng_done;

`ifdef MULPOP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;

    // Counts completed WAIT cycles; the abort fires on the TIMEOUT-th silent one.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)            wait_cnt <= '0;
        else if (state != WAIT)  wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + 1'b1;
    end

    assign to_hit = (state == WAIT) && !bus.eng_done && (wait_cnt == TO_W'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        bus.grant     = '0;
        bus.eng_start = 1'b0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: begin
                bus.grant = pick_gnt;
                if (pick_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.eng_start = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (done_hit || to_hit) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = N_REQ'(1) << idx;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            ptr          <= '0;
            idx          <= '0;
            op_count     <= '0;
            bus.eng_a1   <= '0;
            bus.eng_a2   <= '0;
            bus.rsp_w    <= '0;
            bus.rsp_ones <= '0;
            bus.rsp_ovf  <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                idx        <= pick_idx;
                bus.eng_a1 <= bus.req_a1[int'(pick_idx)*A_W +: A_W];
                bus.eng_a2 <= bus.req_a2[int'(pick_idx)*A_W +: A_W];
            end
            if (done_hit) begin
                bus.rsp_w    <= bus.eng_w;
                bus.rsp_ones <= bus.eng_ones;
                bus.rsp_ovf  <= bus.eng_ovf;
                bus.rsp_err  <= 1'b0;
            end else if (to_hit) begin
                bus.rsp_w    <= '0;
                bus.rsp_ones <= '0;
                bus.rsp_ovf  <= 1'b0;
                bus.rsp_err  <= 1'b1;
            end
            // Completion bookkeeping: the winner drops to lowest priority next round.
            if (state == RESP) begin
                op_count <= op_count + 1'b1;
                ptr      <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mulpop_sched.sv
// Directed + randomized bench for mulpop_sched with a behavioural engine and round-robin model.
module tb_mulpop_sched;
    import mulpop_pkg::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    mulpop_sched_if #(.N_REQ(N)) bus ();

    mulpop_sched #(.N_REQ(N), .TIMEOUT(16)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] a1_v [N];
    logic [23:0] a2_v [N];
    int          eng_lat  = 1;
    bit          eng_hang = 1'b0;
    bit          eng_force = 1'b0;
    logic [31:0] f_w;
    logic [5:0]  f_ones;
    logic        f_ovf;
    int          model_ptr = 0;
    logic [15:0] model_cnt = 16'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural engine: answers eng_start after eng_lat cycles with the true product.
    initial begin : engine
        logic [47:0] p;
        bus.eng_done = 1'b0;
        bus.eng_w    = '0;
        bus.eng_ones = '0;
        bus.eng_ovf  = 1'b0;
        forever begin
            @(negedge clk);
            bus.eng_done = 1'b0;
            if (bus.eng_start === 1'b1 && !eng_hang) begin
                p = 48'(bus.eng_a1) * 48'(bus.eng_a2);
                repeat (eng_lat) @(negedge clk);
                bus.eng_done = 1'b1;
                bus.eng_w    = eng_force ? f_w    : p[31:0];
                bus.eng_ones = eng_force ? f_ones : 6'($countones(p[31:0]));
                bus.eng_ovf  = eng_force ? f_ovf  : (p[47:32] != 16'd0);
            end
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a1[i*24 +: 24] = a1_v[i];
            bus.req_a2[i*24 +: 24] = a2_v[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            a1_v[i] = 24'($urandom);
            a2_v[i] = 24'($urandom);
        end
        drive_ops();
    endtask

    function automatic int model_pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at a falling edge with req already driven; follows one operation to completion.
    task automatic serve_one(input int e, input logic [N-1:0] clr);
        int          cyc;
        bit          got;
        logic [47:0] p;
        logic [31:0] ew;
        logic [5:0]  eo;
        logic        ev;
        int          exp_lat;
        p = 48'(a1_v[e]) * 48'(a2_v[e]);
        if (eng_hang)       begin ew = 32'd0; eo = 6'd0;   ev = 1'b0;  end
        else if (eng_force) begin ew = f_w;   eo = f_ones; ev = f_ovf; end
        else begin
            ew = p[31:0];
            eo = 6'($countones(p[31:0]));
            ev = (p[47:32] != 16'd0);
        end
        exp_lat = eng_hang ? 18 : eng_lat + 2;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.grant != '0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("grant_seen", 64'(got), 64'd1);
        if (!got) return;
        chk($sformatf("grant_idx%0d", e), 64'(bus.grant), 64'(N'(1) << e));
        @(negedge clk);
        cyc = 1;
        bus.req = bus.req & ~clr;
        chk("eng_start", 64'(bus.eng_start), 64'd1);
        chk("eng_a1", 64'(bus.eng_a1), 64'(a1_v[e]));
        chk("eng_a2", 64'(bus.eng_a2), 64'(a2_v[e]));
        got = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid != '0) begin got = 1'b1; break; end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(N'(1) << e));
        chk("rsp_latency", 64'(cyc), 64'(exp_lat));
        chk("rsp_w", 64'(bus.rsp_w), 64'(ew));
        chk("rsp_ones", 64'(bus.rsp_ones), 64'(eo));
        chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(ev));
        chk("rsp_err", 64'(bus.rsp_err), 64'(eng_hang));
        @(negedge clk);
        model_cnt = model_cnt + 16'd1;
        model_ptr = (e + 1) % N;
        chk("op_count", 64'(op_count), 64'(model_cnt));
        chk("rsp_valid_pulse", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin : main
        logic [N-1:0] pend;
        int           e;
        int           vr;
        bus.req = '0;
        for (int i = 0; i < N; i++) begin a1_v[i] = '0; a2_v[i] = '0; end
        drive_ops();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_eng_start", 64'(bus.eng_start), 64'd0);
        chk("rst_rsp_w", 64'(bus.rsp_w), 64'd0);
        chk("rst_eng_a1", 64'(bus.eng_a1), 64'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // All four held high: order 0,1,2,3,0,1,2,3
        rand_ops();
        bus.req = '1;
        for (int op = 0; op < 8; op++) begin
            eng_lat = int'($urandom_range(1, 4));
            serve_one(op % N, (op == 7) ? '1 : '0);
        end
        chk("rr_op_count", 64'(op_count), 64'd8);

        // Single request on requester 2
        a1_v[2] = 24'h000003;
        a2_v[2] = 24'h000005;
        drive_ops();
        eng_lat = 2;
        bus.req = 4'b0100;
        serve_one(2, 4'b0100);
        chk("single_w", 64'(bus.rsp_w), 64'h0000000F);
        chk("single_ones", 64'(bus.rsp_ones), 64'd4);

        // Overflow pass-through with engine-supplied values
        a1_v[0] = 24'hFFFFFF;
        a2_v[0] = 24'hFFFFFF;
        drive_ops();
        eng_force = 1'b1;
        f_w = 32'h00000001; f_ones = 6'd1; f_ovf = 1'b1;
        eng_lat = 3;
        bus.req = 4'b0001;
        serve_one(0, 4'b0001);
        chk("ovf_flag", 64'(bus.rsp_ovf), 64'd1);
        chk("ovf_w", 64'(bus.rsp_w), 64'h00000001);
        eng_force = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_w", 64'(bus.rsp_w), 64'h00000001);

        // Randomized batches of simultaneous requests
        for (int r = 0; r < 8; r++) begin
            rand_ops();
            pend = N'($urandom_range(1, (1 << N) - 1));
            bus.req = pend;
            while (pend != '0) begin
                e = model_pick(pend);
                eng_lat = int'($urandom_range(1, 6));
                serve_one(e, N'(1) << e);
                pend[e] = 1'b0;
            end
        end

        // Counter wrap
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        model_cnt = 16'hFFFF;
        @(negedge clk);
        chk("wrap_preload", 64'(op_count), 64'hFFFF);
        rand_ops();
        eng_lat = 1;
        bus.req = 4'b0010;
        serve_one(1, 4'b0010);
        chk("wrap_zero", 64'(op_count), 64'h0000);

        // Reset while waiting on the engine
        eng_hang = 1'b1;
        rand_ops();
        bus.req = 4'b0010;
        #1;
        chk("mid_grant", 64'(bus.grant), 64'b0010);
        @(negedge clk);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_op_count", 64'(op_count), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_w", 64'(bus.rsp_w), 64'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        eng_hang = 1'b0;
        vr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) vr++;
        end
        chk("mid_no_rsp", 64'(vr), 64'd0);
        model_cnt = 16'd0;
        model_ptr = 0;
        rand_ops();
        pend = 4'b1011;
        bus.req = pend;
        while (pend != '0) begin
            e = model_pick(pend);
            eng_lat = int'($urandom_range(1, 3));
            serve_one(e, N'(1) << e);
            pend[e] = 1'b0;
        end

`ifdef MULPOP_TIMEOUT_EN
        // Silent engine: abort after TIMEOUT wait cycles, then resume normally
        eng_hang = 1'b1;
        rand_ops();
        bus.req = 4'b0100;
        serve_one(model_pick(4'b0100), 4'b0100);
        eng_hang = 1'b0;
        eng_lat = 2;
        bus.req = 4'b1000;
        serve_one(model_pick(4'b1000), 4'b1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mulpop_sched.md
Name: mulpop_sched

Overview:
- Round-robin scheduler that shares one multicycle 24x24 multiply + popcount engine among N_REQ requesters.
- Accepts operand pairs from requesters and issues them to the engine one at a time.
- Returns W (low 32 product bits), ones count and overflow flag to the winning requester.
- Sits between the bus-facing register slices and the single shared arithmetic engine; counts completed operations for the GPIO status output.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(N_REQ), requester index width (derived).
- TIMEOUT, 1023, max WAIT cycles before abort; used only with MULPOP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held until grant.
- req_a1  in  N_REQ*24  packed operand A1, slice i = [24*i+23:24*i].
- req_a2  in  N_REQ*24  packed operand A2, same packing.
- grant  out  N_REQ  one-hot, one-cycle pulse on acceptance.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse when result ready.
- rsp_w  out  32  product[31:0], valid with rsp_valid.
- rsp_ones  out  6  popcount of product[31:0].
- rsp_ovf  out  1  1 when product[47:32] != 0.
- rsp_err  out  1  1 when operation aborted by timeout.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_a1, eng_a2  out  24 each  operands, stable from start until done.
- eng_done  in  1  engine completion pulse.
- eng_w  in  32  engine result W.
- eng_ones  in  6  engine ones count.
- eng_ovf  in  1  engine overflow flag.
- busy  out  1  high in any state except IDLE.
- op_count  out  16  completed-operation counter.

Behaviour:
- Reset, asynchronous: state=IDLE, ptr=0, op_count=0, grant=0, rsp_valid=0, eng_start=0, all data outputs 0. A reset mid-operation discards that operation; no rsp_valid is issued for it.
- IDLE: if any req bit is set, pick the first set bit at or after ptr, wrapping. In the same cycle: pulse grant[idx], latch idx, latch that requester's A1/A2 into eng_a1/eng_a2, go to ISSUE. If no req bit is set, stay in IDLE.
- ISSUE: eng_start=1 for exactly this cycle; go to WAIT.
- WAIT: eng_done is sampled only in WAIT and ignored in every other state. On eng_done, latch eng_w/eng_ones/eng_ovf, clear rsp_err, go to RESP.
- RESP: drive rsp_valid[idx]=1 for one cycle with rsp_w/rsp_ones/rsp_ovf/rsp_err. In the same cycle: op_count += 1 (wraps 0xFFFF -> 0x0000), ptr = (idx+1) mod N_REQ, go to IDLE.
- Data outputs hold their last values until the next RESP.
- Latency: grant at cycle t, eng_start at t+1, rsp_valid one cycle after eng_done. Minimum throughput is one operation per 4 cycles plus engine time.
- A requester re-asserting req immediately after grant is legal; it is served after every other pending requester.
- When all requesters assert together after reset, the order is 0,1,2,...
- Operands are not re-sampled after grant; requester changes after grant have no effect.
- Arithmetic is done by the engine only; the scheduler does no arithmetic beyond the counter, ptr and timeout.

Optional Feature:
- Macro: MULPOP_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. If eng_done is not seen within TIMEOUT cycles, go to RESP with rsp_err=1 and rsp_w/rsp_ones/rsp_ovf=0. op_count still increments.
- Undefined: no counter; WAIT waits indefinitely; rsp_err is tied 0.

Decomposition:
- Package mulpop_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - constants A_W=24, W_W=32, ONES_W=6, CNT_W=16.
- One sub-module, mulpop_rr_pick: combinational round-robin picker. Inputs: req vector and ptr. Outputs: one-hot grant vector, binary index and any flag.

Test Plan:
- Single request: req[2]=1, A1=0x000003, A2=0x000005; engine returns W=15, ones=4, ovf=0 → grant[2] pulse, eng_start next cycle, rsp_valid[2] with W=0x0000000F, ones=4, op_count=1.
- Round robin: all four req held high for 8 operations → grant order 0,1,2,3,0,1,2,3 and op_count=8.
- Overflow pass-through: A1=A2=0xFFFFFF; engine returns W=0x00000001, ones=1, ovf=1 → rsp_ovf=1, rsp_w=0x00000001.
- Reset mid-op: assert n_reset low while in WAIT → busy=0, op_count=0, no rsp_valid; next request is granted normally, with requester 0 first if several are pending.
- Counter wrap: preload 65535 operations (or force op_count=0xFFFF), then run one more → op_count=0x0000.
- With MULPOP_TIMEOUT_EN and TIMEOUT=16: engine never asserts eng_done → rsp_valid exactly 17 cycles after eng_start with rsp_err=1, W=0; the next request proceeds normally.
